// File: rtl/ntt_addr_seq.sv
// Address and twiddle sequencer for the NTT datapath: NTT (Cooley-Tukey), INTT (Gentleman-Sande),
// linear LOAD and linear/bit-reversed STORE, with issue pacing, inter-stage drain and stall.
module ntt_addr_seq #(
   parameter int LOGN       = 8,
   parameter int PACE       = 1,
   parameter int DRAIN      = 4,
   parameter int BREV_STORE = 1,
   parameter int SW         = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      mode,
   input  logic            stall,
   output logic            busy,
   output logic            addr_valid,
   output logic [LOGN-1:0] addr_a,
   output logic [LOGN-1:0] addr_b,
   output logic [LOGN-1:0] tw_idx,
   output logic [SW-1:0]   stage,
   output logic            last,
   output logic            done
);

   localparam int PW = (PACE > 1) ? $clog2(PACE) : 1;
   localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
   localparam logic [PW-1:0]   PACE_LAST  = PW'(PACE - 1);
   localparam logic [DW-1:0]   DRAIN_LAST = DW'((DRAIN > 0) ? DRAIN - 1 : 0);
   localparam logic [LOGN-1:0] ONES       = '1;
   localparam logic [LOGN-1:0] HALF       = LOGN'(1) << (LOGN - 1);
   localparam logic [SW-1:0]   S_LAST     = SW'(LOGN - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]      state;
   logic [1:0]      mode_q;
   logic [LOGN-1:0] j;
   logic [SW-1:0]   s;
   logic [PW-1:0]   pace;
   logic [DW-1:0]   dcnt;

   logic            linear;
   logic            more_stages;
   logic            final_slot;
   logic [LOGN-1:0] j_last;
   logic [SW-1:0]   sh;
   logic [LOGN-1:0] len, g, k, a_full, b_full, tw_full, rev;
   logic [LOGN-1:0] a_next, b_next, tw_next;
   logic [SW-1:0]   stage_next;

   always_comb begin
      linear      = mode_q[1];
      more_stages = !linear && (s != S_LAST);
      j_last      = linear ? ONES : (ONES >> 1);
      final_slot  = (j == j_last) && !more_stages;
      sh          = S_LAST - s;

      // INTT: len doubles per stage and tw = (N>>s)-1-g, written as a shifted mask to stay in LOGN bits
      if (mode_q == 2'b01) begin
         len     = LOGN'(1) << s;
         g       = j >> s;
         tw_full = (ONES >> s) - g;
      end else begin
         len     = HALF >> s;
         g       = j >> sh;
         tw_full = (LOGN'(1) << s) + g;
      end
      k      = j & (len - LOGN'(1));
      a_full = ((g * len) << 1) + k;
      b_full = a_full + len;

      rev = '0;
      for (int unsigned i = 0; i < LOGN; i++) rev[i] = j[LOGN-1-i];

      a_next     = '0;
      b_next     = '0;
      tw_next    = '0;
      stage_next = '0;
      case (mode_q)
         2'b00, 2'b01: begin
            a_next     = a_full;
            b_next     = b_full;
            tw_next    = tw_full;
            stage_next = s;
         end
         2'b10:   a_next = j;
         default: a_next = (BREV_STORE == 1) ? rev : j;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         mode_q     <= '0;
         j          <= '0;
         s          <= '0;
         pace       <= '0;
         dcnt       <= '0;
         busy       <= 1'b0;
         addr_valid <= 1'b0;
         addr_a     <= '0;
         addr_b     <= '0;
         tw_idx     <= '0;
         stage      <= '0;
         last       <= 1'b0;
         done       <= 1'b0;
      end else begin
         addr_valid <= 1'b0;
         last       <= 1'b0;
         done       <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  mode_q <= mode;
                  j      <= '0;
                  s      <= '0;
                  pace   <= '0;
                  busy   <= 1'b1;
                  state  <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (!stall) begin
                  if (pace == '0) begin
                     addr_valid <= 1'b1;
                     addr_a     <= a_next;
                     addr_b     <= b_next;
                     tw_idx     <= tw_next;
                     stage      <= stage_next;
                     last       <= final_slot;
                  end
                  // With PACE=1 the slot start and slot completion fall on the same edge
                  if (pace == PACE_LAST) begin
                     pace <= '0;
                     if (j == j_last) begin
                        j <= '0;
                        if (DRAIN == 0) begin
                           if (more_stages) s <= s + 1'b1;
                           else             state <= S_DONE;
                        end else begin
                           dcnt  <= '0;
                           state <= S_DRAIN;
                        end
                     end else begin
                        j <= j + 1'b1;
                     end
                  end else begin
                     pace <= pace + 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               if (!stall) begin
                  if (dcnt == DRAIN_LAST) begin
                     if (more_stages) begin
                        s     <= s + 1'b1;
                        state <= S_ISSUE;
                     end else begin
                        state <= S_DONE;
                     end
                  end else begin
                     dcnt <= dcnt + 1'b1;
                  end
               end
            end
            default: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ntt_addr_seq.sv
// Directed bench for ntt_addr_seq: LOGN=3/PACE=2/DRAIN=1 sequences plus a LOGN=8/PACE=1/DRAIN=0 corner instance.
module tb_ntt_addr_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [1:0] mode = 2'b00;
   logic       stall = 1'b0;
   logic       busy, addr_valid, last, done;
   logic [2:0] addr_a, addr_b, tw_idx;
   logic [3:0] stage;

   logic       c_start = 1'b0;
   logic [1:0] c_mode = 2'b00;
   logic       c_stall = 1'b0;
   logic       c_busy, c_addr_valid, c_last, c_done;
   logic [7:0] c_addr_a, c_addr_b, c_tw_idx;
   logic [3:0] c_stage;

   int n_cmp = 0;
   int n_err = 0;

   int exp_a [12];
   int exp_b [12];
   int exp_tw[12];
   int exp_st[12];
   int exp_t [12];

   always #5 clk = ~clk;

   ntt_addr_seq #(.LOGN(3), .PACE(2), .DRAIN(1), .BREV_STORE(1), .SW(4)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .stall(stall),
      .busy(busy), .addr_valid(addr_valid), .addr_a(addr_a), .addr_b(addr_b),
      .tw_idx(tw_idx), .stage(stage), .last(last), .done(done)
   );

   ntt_addr_seq #(.LOGN(8), .PACE(1), .DRAIN(0), .BREV_STORE(1), .SW(4)) dut_c (
      .clk(clk), .rst(rst), .start(c_start), .mode(c_mode), .stall(c_stall),
      .busy(c_busy), .addr_valid(c_addr_valid), .addr_a(c_addr_a), .addr_b(c_addr_b),
      .tw_idx(c_tw_idx), .stage(c_stage), .last(c_last), .done(c_done)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int idx, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s[%0d]: observed %0d expected %0d", tag, idx, got, exp);
      end
   endtask

   // Starts an operation and follows it to done; stall is high for cycles [st_at, st_at+st_len)
   // counted from the acceptance edge (0). A start with another mode is pulsed while busy.
   task automatic run_op(input string nm, input logic [1:0] m, input int ns, input int done_off,
                         input int st_at, input int st_len);
      int  idx;
      bit  seen;
      idx  = 0;
      seen = 1'b0;
      mode  = m;
      start = 1'b1;
      stall = (st_at == 0) && (st_len > 0);
      tick;
      for (int c = 1; c <= done_off + 3 && !seen; c++) begin
         stall = (c >= st_at) && (c < st_at + st_len);
         start = (c == 4);
         mode  = (c == 4) ? (m ^ 2'b10) : m;
         tick;
         if (c == 1) chk({nm, "_busy_first"}, c, busy, 1);
         if (stall) chk({nm, "_valid_in_stall"}, c, addr_valid, 0);
         if (addr_valid) begin
            if (idx < ns) begin
               chk({nm, "_addr_a"}, idx, addr_a, exp_a[idx]);
               chk({nm, "_addr_b"}, idx, addr_b, exp_b[idx]);
               chk({nm, "_tw_idx"}, idx, tw_idx, exp_tw[idx]);
               chk({nm, "_stage"},  idx, stage,  exp_st[idx]);
               chk({nm, "_slot_t"}, idx, c,      exp_t[idx]);
               chk({nm, "_last"},   idx, last,   (idx == ns - 1) ? 1 : 0);
            end
            idx++;
         end
         if (done) begin
            seen = 1'b1;
            chk({nm, "_done_t"}, 0, c, done_off);
            chk({nm, "_busy_at_done"}, 0, busy, 0);
         end
      end
      start = 1'b0;
      stall = 1'b0;
      mode  = m;
      chk({nm, "_slot_count"}, 0, idx, ns);
      chk({nm, "_done_seen"}, 0, seen, 1);
   endtask

   initial begin
      int cnt, first_gap, done_t, lt, la, lb, ltw, fa, fb, ftw;

      // Reset state
      tick;
      tick;
      chk("rst_busy", 0, busy, 0);
      chk("rst_valid", 0, addr_valid, 0);
      chk("rst_done", 0, done, 0);
      chk("rst_addr_a", 0, addr_a, 0);
      rst = 1'b0;

      // NTT
      exp_a  = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
      exp_b  = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
      exp_tw = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 5, 6, 7};
      exp_st = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
      exp_t  = '{1, 3, 5, 7, 10, 12, 14, 16, 19, 21, 23, 25};
      run_op("ntt", 2'b00, 12, 28, 0, 0);

      // INTT
      exp_a  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
      exp_b  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
      exp_tw = '{7, 6, 5, 4, 3, 3, 2, 2, 1, 1, 1, 1};
      run_op("intt", 2'b01, 12, 28, 0, 0);

      // NTT with 3 stall cycles on the second slot of stage 1
      exp_a  = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
      exp_b  = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
      exp_tw = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 5, 6, 7};
      exp_t  = '{1, 3, 5, 7, 10, 15, 17, 19, 22, 24, 26, 28};
      run_op("ntt_stall", 2'b00, 12, 31, 12, 3);

      // LOAD
      exp_a  = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 0, 0, 0};
      exp_b  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      exp_tw = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      exp_st = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      exp_t  = '{1, 3, 5, 7, 9, 11, 13, 15, 0, 0, 0, 0};
      run_op("load", 2'b10, 8, 18, 0, 0);

      // STORE (bit-reversed)
      exp_a  = '{0, 4, 2, 6, 1, 5, 3, 7, 0, 0, 0, 0};
      run_op("store", 2'b11, 8, 18, 0, 0);

      // Reset in the middle of INTT stage 1
      mode  = 2'b01;
      start = 1'b1;
      tick;
      start = 1'b0;
      repeat (12) tick;
      chk("pre_rst_addr_b", 0, addr_b, 3);
      chk("pre_rst_stage", 0, stage, 1);
      rst = 1'b1;
      #1;
      chk("midrst_busy", 0, busy, 0);
      chk("midrst_addr_a", 0, addr_a, 0);
      chk("midrst_addr_b", 0, addr_b, 0);
      chk("midrst_tw_idx", 0, tw_idx, 0);
      chk("midrst_stage", 0, stage, 0);
      chk("midrst_valid", 0, addr_valid, 0);
      chk("midrst_last", 0, last, 0);
      chk("midrst_done", 0, done, 0);
      tick;
      rst = 1'b0;
      tick;
      tick;
      exp_a = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 0, 0, 0};
      run_op("load_after_rst", 2'b10, 8, 18, 0, 0);

      // STORE accepted with stall high; first slot waits for stall to fall
      exp_a = '{0, 4, 2, 6, 1, 5, 3, 7, 0, 0, 0, 0};
      exp_t = '{3, 5, 7, 9, 11, 13, 15, 17, 0, 0, 0, 0};
      run_op("store_start_stall", 2'b11, 8, 20, 0, 3);

      // Corner instance: LOGN=8, PACE=1, DRAIN=0 NTT
      cnt = 0; first_gap = 0; done_t = 0; lt = 0;
      la = 0; lb = 0; ltw = 0; fa = -1; fb = -1; ftw = -1;
      c_mode  = 2'b00;
      c_start = 1'b1;
      tick;
      c_start = 1'b0;
      for (int c = 1; c <= 1100 && done_t == 0; c++) begin
         tick;
         if (c_addr_valid) begin
            cnt++;
            if (first_gap == 0 && c != cnt) first_gap = c;
            if (cnt == 1) begin
               fa = c_addr_a; fb = c_addr_b; ftw = c_tw_idx;
            end
            la = c_addr_a; lb = c_addr_b; ltw = c_tw_idx; lt = c_last;
         end
         if (c_done) done_t = c;
      end
      chk("corner_strobes", 0, cnt, 1024);
      chk("corner_first_gap_cycle", 0, first_gap, 0);
      chk("corner_first_a", 0, fa, 0);
      chk("corner_first_b", 0, fb, 128);
      chk("corner_first_tw", 0, ftw, 1);
      chk("corner_final_a", 0, la, 254);
      chk("corner_final_b", 0, lb, 255);
      chk("corner_final_tw", 0, ltw, 255);
      chk("corner_final_last", 0, lt, 1);
      chk("corner_done_t", 0, done_t, 1025);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
